// File: rtl/uart_pkg.sv
// Shared UART transmit-path definitions: byte width, default line rate and arbiter state encoding.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int CLK_FREQ    = 50_000_000;
  localparam int BAUD        = 115_200;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_OWN,
    ARB_START,
    ARB_ACK,
    ARB_DONE
  } arb_state_e;

  // Index reached after stepping 'step' places from 'idx' around a ring of 'n'.
  function automatic int rr_next(input int idx, input int step, input int n);
    return (idx + step) % n;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping around.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every always_comb output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'(rr_next(int'(ptr), k, N_REQ));
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

  always_comb begin
    pick      = '0;
    pick[idx] = any;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx between N_REQ byte-stream requesters.
// Define UART_ARB_TIMEOUT_EN to release an owner that stalls TIMEOUT cycles mid-message.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic [N_REQ-1:0]             grant,
  output logic [UART_BYTE_W-1:0]       tx_data,
  output logic                         tx_start,
  input  logic                         tx_busy,
  output logic                         timeout_evt
);

  localparam int               IDX_W   = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT 1..65535");
  end

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, owner_q, pick_idx;
  logic [N_REQ-1:0]       pick_onehot;
  logic                   pick_any;
  logic                   last_q;
  logic                   handshake;
  logic                   release_grant;
  logic                   to_fire;
  logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
  end

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req_valid),
    .ptr  (ptr_q),
    .pick (pick_onehot),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign handshake     = (state_q == ARB_OWN) && req_valid[owner_q] && !tx_busy;
  assign release_grant = ((state_q == ARB_DONE) && !tx_busy && last_q) || to_fire;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_OWN;
      ARB_OWN: begin
        if (handshake)    state_d = ARB_START;
        else if (to_fire) state_d = ARB_IDLE;
      end
      ARB_START: state_d = ARB_ACK;
      ARB_ACK:   if (tx_busy) state_d = ARB_DONE;
      ARB_DONE:  if (!tx_busy) state_d = last_q ? ARB_IDLE : ARB_OWN;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = handshake;
  end

  // Grant, pointer and the captured byte; the grant releases only after the last byte clears the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      ptr_q    <= PTR_RST;
      owner_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      tx_start <= handshake;
      if (state_q == ARB_IDLE && pick_any) begin
        owner_q <= pick_idx;
        grant   <= pick_onehot;
      end
      if (handshake) begin
        tx_data <= req_bytes[owner_q];
        last_q  <= req_last[owner_q];
      end
      if (release_grant) begin
        grant <= '0;
        ptr_q <= owner_q;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] to_cnt;

  // Held at zero outside OWN, so it is already clear whenever OWN is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= to_fire;
      if (state_q != ARB_OWN || handshake) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 16'd1;
    end
  end

  assign to_fire = (state_q == ARB_OWN) && !handshake && (to_cnt == TO_LAST);
`else
  assign to_fire     = 1'b0;
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences and randomized messages.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int TO = 50;

  logic                   clk       = 1'b0;
  logic                   rst       = 1'b1;
  logic [N-1:0]           req_valid = '0;
  logic [UART_BYTE_W*N-1:0] req_data = '0;
  logic [N-1:0]           req_last  = '0;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           grant;
  logic [UART_BYTE_W-1:0] tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   timeout_evt;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Serializer stand-in: busy one cycle after start, for a frame of cycles; logs every byte put on the line.
  int         ser_cnt        = 0;
  bit         rand_frame     = 1'b0;
  bit         force_busy     = 1'b0;
  bit         force_busy_nxt = 1'b0;
  logic [7:0] line_q[$];

  always @(posedge clk) begin
    if (rst) ser_cnt <= 0;
    else if (tx_start) begin
      ser_cnt <= rand_frame ? int'($urandom_range(12, 2)) : 10;
      line_q.push_back(tx_data);
    end else if (ser_cnt != 0) ser_cnt <= ser_cnt - 1;
  end

  assign tx_busy = force_busy || (ser_cnt != 0);

  // Requester stand-ins: per-requester byte queues with optional mid-message gaps.
  logic [7:0]   bq[N][$];
  bit           lq[N][$];
  int           gap[N];
  int           gap_max = 0;
  int           gorder[$];
  logic [N-1:0] grant_prev = '0;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_byte;
  } vec_t;

  vec_t vecs[8];

  int         mlen[N][$];
  logic [7:0] mbytes[N][$];
  logic [7:0] exp_line[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int i = 0; i < N; i++) if (bq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] b, input bit last);
    bq[r].push_back(b);
    lq[r].push_back(last);
  endtask

  // One clock cycle: drive after the edge, sample at the falling edge, retire accepted bytes.
  task automatic tick(input bit r = 1'b0);
    bit wl;
    @(posedge clk);
    #1;
    rst        = r;
    force_busy = force_busy_nxt;
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (bq[i].size() > 0) && (gap[i] == 0);
      req_data[i*8 +: 8]   = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
      req_last[i]          = (bq[i].size() > 0) ? lq[i][0] : 1'b0;
    end
    @(negedge clk);
    cyc++;
    check("ready_onehot_in_grant",
          32'($onehot0(req_ready) && ((req_ready & ~grant) == '0)), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (bq[i].size() > 0) begin
          wl = lq[i][0];
          void'(bq[i].pop_front());
          void'(lq[i].pop_front());
          gap[i] = wl ? 0 : int'($urandom_range(gap_max, 0));
        end
      end else if (gap[i] > 0) gap[i]--;
    end
    if (grant != '0 && grant_prev == '0) gorder.push_back(onehot_idx(grant));
    grant_prev = grant;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      lq[i].delete();
      gap[i] = 0;
    end
    force_busy_nxt = 1'b0;
    tick(1'b1);
    tick(1'b1);
    line_q.delete();
    gorder.delete();
    tick(1'b0);
  endtask

  task automatic run_until_idle(input int budget, input string name);
    int  n    = 0;
    bit  done = 1'b0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = all_empty() && (grant == '0) && !tx_busy && !tx_start;
    end
    check({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic check_line(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(line_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < line_q.size(); i++)
      check({name, "_byte"}, 32'(line_q[i]), 32'(exp[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         fall_at, evt_at, evt_n, starts, p, sel, len, n;
    bit         seen_busy, ok_grant, ok_ready, found;
    logic [7:0] exp[$];
    logic [N-1:0] grant_at_evt;

    vecs[0] = '{4'b0001, 4'b0001, 8'h30};
    vecs[1] = '{4'b1111, 4'b0010, 8'h31};
    vecs[2] = '{4'b0011, 4'b0001, 8'h30};
    vecs[3] = '{4'b1000, 4'b1000, 8'h33};
    vecs[4] = '{4'b1010, 4'b0010, 8'h31};
    vecs[5] = '{4'b0110, 4'b0100, 8'h32};
    vecs[6] = '{4'b0100, 4'b0100, 8'h32};
    vecs[7] = '{4'b1001, 4'b1000, 8'h33};

    // Reset values.
    do_reset();
    check("rst_grant",       32'(grant),       32'd0);
    check("rst_tx_data",     32'(tx_data),     32'd0);
    check("rst_tx_start",    32'(tx_start),    32'd0);
    check("rst_req_ready",   32'(req_ready),   32'd0);
    check("rst_timeout_evt", 32'(timeout_evt), 32'd0);

    // Vector table: one-byte requests from a mask, pointer carried from the previous winner.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < N; i++)
        if (vecs[v].mask[i]) push_byte(i, 8'(8'h30 + i), 1'b1);
      tick();
      tick();
      check("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
      for (int i = 0; i < N; i++)
        if (!vecs[v].exp_grant[i]) begin
          bq[i].delete();
          lq[i].delete();
        end
      run_until_idle(200, "vec");
      check("vec_byte", 32'((line_q.size() > 0) ? line_q[line_q.size()-1] : 8'hxx),
            32'(vecs[v].exp_byte));
    end

    // Single requester, single byte: exact grant / start / release timing.
    do_reset();
    push_byte(0, 8'h41, 1'b1);
    tick();
    check("t1_grant_req_cycle", 32'(grant), 32'd0);
    tick();
    check("t1_grant", 32'(grant), 32'b0001);
    check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    check("t1_tx_start", 32'(tx_start), 32'd1);
    check("t1_tx_data", 32'(tx_data), 32'h41);
    seen_busy = 1'b0;
    n = 0;
    while (!(seen_busy && !tx_busy) && n < 100) begin
      if (tx_busy) seen_busy = 1'b1;
      if (!(seen_busy && !tx_busy)) tick();
      n++;
    end
    check("t1_busy_fell", 32'(seen_busy && !tx_busy), 32'd1);
    check("t1_grant_at_fall", 32'(grant), 32'b0001);
    tick();
    check("t1_grant_released", 32'(grant), 32'd0);

    // Two simultaneous 3-byte messages never interleave; then 3 beats a re-asserting 1.
    do_reset();
    push_byte(1, "A", 1'b0); push_byte(1, "B", 1'b0); push_byte(1, "C", 1'b1);
    push_byte(2, "x", 1'b0); push_byte(2, "y", 1'b0); push_byte(2, "z", 1'b1);
    run_until_idle(400, "t2a");
    push_byte(1, "Q", 1'b1);
    push_byte(3, "R", 1'b1);
    tick();
    tick();
    check("t2_grant_r3", 32'(grant), 32'b1000);
    run_until_idle(200, "t2b");
    exp = '{"A", "B", "C", "x", "y", "z", "R", "Q"};
    check_line("t2_line", exp);

    // All four requesters continuously busy with one-byte messages: strict rotation.
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++) push_byte(i, 8'(16 * i + m), 1'b1);
    run_until_idle(600, "t3");
    check("t3_grants", 32'(gorder.size()), 32'd8);
    for (int k = 0; k < 8 && k < gorder.size(); k++)
      check("t3_grant_order", 32'(gorder[k]), 32'(k % N));

    // Owner 2 stalls mid-message for 100 cycles while requester 0 waits.
    do_reset();
    push_byte(2, 8'h21, 1'b0);
    push_byte(2, 8'h22, 1'b1);
    n = 0;
    while (req_ready[2] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("t4_first_accept", 32'(req_ready[2]), 32'd1);
    gap[2] = 100;
    push_byte(0, 8'h01, 1'b1);
    ok_grant = 1'b1; ok_ready = 1'b1; seen_busy = 1'b0;
    fall_at = -1; evt_at = -1; evt_n = 0; grant_at_evt = '1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (grant != 4'b0100) ok_grant = 1'b0;
      if (req_ready[0]) ok_ready = 1'b0;
      if (seen_busy && !tx_busy && fall_at < 0) fall_at = cyc;
      if (tx_busy) seen_busy = 1'b1;
      if (timeout_evt) begin
        evt_n++;
        evt_at = cyc;
        grant_at_evt = grant;
      end
    end
`ifdef UART_ARB_TIMEOUT_EN
    check("t4_evt_count", 32'(evt_n), 32'd1);
    check("t4_evt_delay", 32'(evt_at - fall_at), 32'(TO + 1));
    check("t4_grant_at_evt", 32'(grant_at_evt), 32'd0);
    check("t4_next_owner", 32'((gorder.size() > 1) ? gorder[1] : -1), 32'd0);
    run_until_idle(300, "t4");
    exp = '{8'h21, 8'h01, 8'h22};
`else
    check("t4_grant_held", 32'(ok_grant), 32'd1);
    check("t4_no_ready_r0", 32'(ok_ready), 32'd1);
    check("t4_no_evt", 32'(evt_n), 32'd0);
    run_until_idle(300, "t4");
    exp = '{8'h21, 8'h22, 8'h01};
`endif
    check_line("t4_line", exp);

    // Reset during DONE of byte 2 of a 4-byte message.
    do_reset();
    for (int b = 0; b < 4; b++) push_byte(2, 8'(8'h50 + b), b == 3);
    starts = 0; n = 0;
    while (starts < 2 && n < 100) begin
      tick();
      if (tx_start) starts++;
      n++;
    end
    n = 0;
    while (!tx_busy && n < 10) begin
      tick();
      n++;
    end
    check("t5_reached_ack", 32'(tx_busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      lq[i].delete();
    end
    tick(1'b1);
    tick();
    check("t5_rst_grant",       32'(grant),       32'd0);
    check("t5_rst_tx_data",     32'(tx_data),     32'd0);
    check("t5_rst_tx_start",    32'(tx_start),    32'd0);
    check("t5_rst_req_ready",   32'(req_ready),   32'd0);
    check("t5_rst_timeout_evt", 32'(timeout_evt), 32'd0);
    push_byte(3, 8'h63, 1'b1);
    push_byte(1, 8'h61, 1'b1);
    push_byte(0, 8'h60, 1'b1);
    tick();
    tick();
    check("t5_first_after_rst", 32'(grant), 32'b0001);
    run_until_idle(300, "t5");

    // Serializer busy from outside: the handshake waits for it and happens in the falling cycle.
    do_reset();
    force_busy_nxt = 1'b1;
    push_byte(1, 8'h5A, 1'b1);
    tick();
    ok_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (req_ready != '0) ok_ready = 1'b0;
    end
    check("t6_grant", 32'(grant), 32'b0010);
    check("t6_ready_held_off", 32'(ok_ready), 32'd1);
    force_busy_nxt = 1'b0;
    tick();
    check("t6_ready_on_fall", 32'(req_ready), 32'b0010);
    tick();
    check("t6_tx_start", 32'(tx_start), 32'd1);
    check("t6_tx_data", 32'(tx_data), 32'h5A);
    run_until_idle(100, "t6");

    // Randomized messages against a message-level round-robin model.
    rand_frame = 1'b1;
    gap_max    = 3;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      exp_line.delete();
      for (int i = 0; i < N; i++) begin
        mlen[i].delete();
        mbytes[i].delete();
        for (int m = 0; m < int'($urandom_range(3, 0)); m++) begin
          len = int'($urandom_range(4, 1));
          mlen[i].push_back(len);
          for (int b = 0; b < len; b++) begin
            mbytes[i].push_back(8'($urandom));
            push_byte(i, mbytes[i][mbytes[i].size()-1], b == len - 1);
          end
        end
      end
      p = N - 1;
      found = 1'b1;
      while (found) begin
        found = 1'b0;
        sel = 0;
        for (int k = 1; k <= N; k++)
          if (!found && mlen[(p + k) % N].size() > 0) begin
            found = 1'b1;
            sel = (p + k) % N;
          end
        if (found) begin
          len = mlen[sel].pop_front();
          for (int b = 0; b < len; b++) exp_line.push_back(mbytes[sel].pop_front());
          p = sel;
        end
      end
      run_until_idle(20000, "rand");
      check_line("rand_line", exp_line);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer between `N_REQ` independent byte-stream requesters. Arbitration is round-robin at message granularity: a requester keeps the grant until its byte flagged `req_last` has fully left the line. The block sits between on-chip producers (debug printers, status reporters, command responders) and the single `uart_tx` instance. It drives that instance's `data`/`start` and observes its `busy`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 65535: idle cycles an owner may stall mid-message before forced release. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, shared with `uart_tx`.
- `rst` in 1: reset. Synchronous and active-high.
- `req_valid` in N_REQ: per-requester byte available.
- `req_data` in 8*N_REQ: byte for requester i at bits [8i+7:8i].
- `req_last` in N_REQ: the offered byte ends the message.
- `req_ready` out N_REQ: byte accepted this cycle; combinational, one-hot or zero.
- `grant` out N_REQ: registered one-hot grant to the current owner; zero when no owner.
- `tx_data` out 8: registered byte to `uart_tx.data`.
- `tx_start` out 1: registered single-cycle pulse to `uart_tx.start`.
- `tx_busy` in 1: from `uart_tx.busy`.
- `timeout_evt` out 1: single-cycle pulse on forced release. Held at 0 when the feature is compiled out.

## Operation
States:
- **IDLE**: `grant`=0.
  - If any `req_valid` is set, select the first set bit searching from `(ptr+1) mod N_REQ` upward with wrap.
  - Latch it as `owner` and go to **OWN**.
- **OWN**: handshake when `req_valid[owner] && !tx_busy`.
  - `req_ready[owner]`=1 in that cycle.
  - Capture `req_data[owner]` into `tx_data` and `req_last[owner]` into `last_q`.
  - Go to **START**.
- **START**: `tx_start`=1 for this cycle only. Go to **ACK**.
- **ACK**: wait for `tx_busy`=1, then go to **DONE**.
- **DONE**: wait for `tx_busy`=0.
  - If `last_q`=1: set `ptr`=`owner`, clear `grant`, go to **IDLE**.
  - Otherwise return to **OWN**.

Rules:
- Only the owner can be granted `req_ready`. `req_valid` from non-owners is ignored until the grant is released.
- A requester holding `req_valid` with `req_last`=1 on its first byte sends a one-byte message.
- Requesters must hold `req_data` and `req_last` stable while `req_valid` is high and not yet accepted.
- Simultaneous requests are resolved purely by pointer order. After reset `ptr`=N_REQ-1, so requester 0 wins first.
- Deassertion of `req_valid[owner]` in OWN keeps the grant; the owner keeps the line.

## Timing
- Reset values: `grant`=0, `tx_data`=0x00, `tx_start`=0, `req_ready`=0, `timeout_evt`=0, `ptr`=N_REQ-1, state=IDLE.
- Request to grant: `req_valid` seen in cycle T (IDLE) → `grant` set and OWN in T+1. Earliest `req_ready` is T+1.
- Handshake in cycle H → `tx_start`=1 in H+1 → `tx_busy` rises in H+2 (one-cycle response of `uart_tx`).
- Per-byte overhead beyond the serializer frame: 3 cycles (OWN, START, ACK), plus 1 cycle to return from DONE.
- Message end: `tx_busy` falls in cycle F → `grant`=0 and IDLE in F+1. Next grant no earlier than F+2.
- Reset mid-message: the next edge returns all outputs to their reset values. A partially sent frame is abandoned; `uart_tx` shares `rst`.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to OWN and on every handshake.
  - It increments each OWN cycle without a handshake.
  - At `TIMEOUT` it clears `grant`, sets `ptr`=`owner`, pulses `timeout_evt` for one cycle, and goes to IDLE.
  - The counter is inactive in START/ACK/DONE.
- Not defined: no counter; an owner may hold the grant indefinitely; `timeout_evt` is tied to 0.

## Structure
- Shared package `uart_pkg`:
  - Arbiter state encoding (IDLE, OWN, START, ACK, DONE).
  - `UART_BYTE_W`=8.
  - Default `CLK_FREQ` and `BAUD` constants shared with `uart_tx`.
- One sub-module, `uart_rr_pick`: combinational round-robin pick. Inputs are the request vector and `ptr`; outputs are a one-hot pick, an index, and `any`.

## Test plan
- Single requester, reset then `req_valid[0]`=1, `req_data`=0x41, `req_last`=1 → `grant`=0001 one cycle later; `tx_start` pulse carrying 0x41; `grant`=0 the cycle after `tx_busy` falls.
- Requesters 1 and 2 both send 3-byte messages ("ABC", "xyz") at once → line carries A,B,C then x,y,z with no interleave. After that, requester 3 asserting beats a re-asserting requester 1.
- All four requesters hold `req_valid` continuously with 1-byte messages → grant order 0,1,2,3,0 and `req_ready` is one-hot every time.
- Owner 2 drops `req_valid` for 100 cycles mid-message while requester 0 requests → `grant` stays 0100 and requester 0 sees no `req_ready`. With `UART_ARB_TIMEOUT_EN` and `TIMEOUT`=50: `timeout_evt` pulses after 50 idle cycles and requester 0 is granted next.
- `rst` asserted during DONE of byte 2 of a 4-byte message → next cycle all outputs at reset values. After release, requester 0 wins first.
- `tx_busy` held high externally while owner has valid data → `req_ready` stays 0 until `tx_busy` falls, then the handshake occurs that cycle.
